// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding, latch indices and flush masks for pipeline_ctrl
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int L_S1S2 = 0;
    localparam int L_S2S3 = 1;
    localparam int L_S3S4 = 2;
    localparam int L_S4S5 = 3;

    localparam logic [3:0] FLUSH_BRANCH  = 4'b0011;
    localparam logic [3:0] FLUSH_LOADUSE = 4'b0010;
    // Load-use holds PC, s1_s2 and s2_s3; only the downstream latches advance.
    localparam logic [3:0] EN_LOADUSE    = 4'b1100;

endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// rtl/pipeline_ctrl_perf_cnt.sv - saturating event counter used by pipeline_ctrl when PIPE_PERF_CNT_EN is defined
module pipe_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipe; PIPE_PERF_CNT_EN adds perf counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NLATCH      = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              halt_req,
    output logic              pc_en,
    output logic [NLATCH-1:0] latch_en,
    output logic [NLATCH-1:0] latch_flush,
    output logic              halted,
    output logic              mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events,
    output logic [CNT_W-1:0]  memwait_cycles
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    // Set once halt_req has been seen high in HALT; exit needs it plus halt_req low.
    logic               armed_q, armed_d;

    logic               adv_pc_en;
    logic [NLATCH-1:0]  adv_en;
    logic [NLATCH-1:0]  adv_flush;
    logic               adv_halt;

    logic               pc_en_c;
    logic [NLATCH-1:0]  en_c;
    logic [NLATCH-1:0]  flush_c;
    logic               halted_c;

    // Outputs of a cycle in which the pipe is free to advance (RUN priorities below memory stall).
    always_comb begin
        adv_pc_en = 1'b1;
        adv_en    = '1;
        adv_flush = '0;
        adv_halt  = 1'b0;
        if (branch_taken) begin
            adv_flush = NLATCH'(FLUSH_BRANCH);
        end else if (load_use) begin
            adv_pc_en = 1'b0;
            adv_en    = NLATCH'(EN_LOADUSE);
            adv_flush = NLATCH'(FLUSH_LOADUSE);
        end else if (halt_req) begin
            adv_pc_en = 1'b0;
            adv_en    = '0;
            adv_halt  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        armed_d    = armed_q;
        pc_en_c    = 1'b0;
        en_c       = '0;
        flush_c    = '0;
        halted_c   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    pc_en_c = adv_pc_en;
                    en_c    = adv_en;
                    flush_c = adv_flush;
                    if (adv_halt) begin
                        state_d = HALT;
                        armed_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    pc_en_c    = adv_pc_en;
                    en_c       = adv_en;
                    flush_c    = adv_flush;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    flush_c[L_S4S5] = 1'b1;
                    state_d         = HALT;
                    wait_cnt_d      = '0;
                    mem_err_d       = 1'b1;
                    armed_d         = halt_req;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                halted_c = 1'b1;
                armed_d  = armed_q | halt_req;
                if (armed_q && !halt_req) begin
                    state_d = RUN;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            armed_q    <= armed_d;
        end
    end

    assign pc_en       = rst ? 1'b0 : pc_en_c;
    assign latch_en    = rst ? '0 : en_c;
    assign latch_flush = rst ? '1 : flush_c;
    assign halted      = rst ? 1'b0 : halted_c;
    assign mem_err     = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc, flush_inc, memwait_inc;

    assign stall_inc   = !rst && !pc_en_c && (state_q != HALT);
    assign flush_inc   = !rst && (|flush_c);
    assign memwait_inc = !rst && (state_q == MEM_WAIT);

    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (memwait_inc),
        .count (memwait_cycles)
    );
`endif

endmodule
